// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared defaults and types for the port-0 SRAM controller
package sram_ctrl_pkg;
  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 10;
  localparam int DEFAULT_NUM_WMASKS = 1;
  typedef enum logic {INIT, RUN} state_t;
  typedef struct packed {
    logic valid;
    logic client_id;
  } rd_entry_t;
endpackage

// File: rtl/sram_port0_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant; pointer moves only on a granted handshake
module rr_arb2 (
  input  logic       clk0,
  input  logic       rstb0,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant
);
  logic last;
  always_comb grant = !en ? 2'b00 : &valid ? (last ? 2'b01 : 2'b10) : valid;
  // last resets to client 1 so client 0 wins the first tie
  always_ff @(posedge clk0) last <= !rstb0 ? 1'b1 : |grant ? grant[1] : last;
endmodule

// File: rtl/sram_port0_arbiter.sv
// sram_port0_arbiter: round-robin sequencer for SRAM port 0 with 2-cycle read return
// SRAM_PORT0_INIT_EN adds an INIT state that zero-fills the whole macro after reset.
module sram_port0_arbiter #(
  parameter int DATA_WIDTH = sram_ctrl_pkg::DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = sram_ctrl_pkg::DEFAULT_ADDR_WIDTH,
  parameter int NUM_WMASKS = sram_ctrl_pkg::DEFAULT_NUM_WMASKS
) (
  input  logic                    clk0,
  input  logic                    rstb0,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_we,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  input  logic [2*NUM_WMASKS-1:0] req_wmask,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    csb0,
  output logic                    web0,
  output logic [NUM_WMASKS-1:0]   wmask0,
  output logic [ADDR_WIDTH-1:0]   addr0,
  output logic [DATA_WIDTH-1:0]   din0,
  input  logic [DATA_WIDTH-1:0]   dout0,
  output logic                    init_done
);
  import sram_ctrl_pkg::*;
  state_t state, state_nx;
  logic [1:0] grant;
  logic hs, id, we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [NUM_WMASKS-1:0] wmask;
  rd_entry_t p0, p1;
  rr_arb2 u_arb (.clk0, .rstb0, .en(rstb0 && state == RUN), .valid(req_valid), .grant);
  always_comb begin
    hs    = |grant;
    id    = grant[1];
    we    = id ? req_we[1] : req_we[0];
    addr  = id ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
    wdata = id ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
    wmask = id ? req_wmask[2*NUM_WMASKS-1:NUM_WMASKS] : req_wmask[NUM_WMASKS-1:0];
  end
`ifdef SRAM_PORT0_INIT_EN
  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  logic [ADDR_WIDTH:0] cnt;
  always_ff @(posedge clk0) begin
    state <= !rstb0 ? INIT : state_nx;
    cnt   <= (!rstb0 || state != INIT) ? '0 : cnt + (ADDR_WIDTH+1)'(1);
  end
  always_comb state_nx = (state == INIT && cnt == (ADDR_WIDTH+1)'(RAM_DEPTH-1)) ? RUN : state;
  always_comb begin
    req_ready = grant;
    init_done = state == RUN;
  end
`else
  always_ff @(posedge clk0) state <= !rstb0 ? RUN : state_nx;
  always_comb state_nx = RUN;
  always_comb begin
    req_ready = grant;
    init_done = 1'b1;
  end
`endif
  // macro pins are always registered; addr/din/wmask hold when idle
  always_ff @(posedge clk0) begin
    if (!rstb0) begin
      csb0      <= 1'b1;
      web0      <= 1'b1;
      wmask0    <= '0;
      addr0     <= '0;
      din0      <= '0;
      p0        <= '0;
      p1        <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
`ifdef SRAM_PORT0_INIT_EN
      if (state == INIT) begin
        csb0   <= 1'b0;
        web0   <= 1'b0;
        wmask0 <= '1;
        addr0  <= cnt[ADDR_WIDTH-1:0];
        din0   <= '0;
      end else
`endif
      if (hs) begin
        csb0   <= 1'b0;
        web0   <= ~we;
        wmask0 <= wmask;
        addr0  <= addr;
        din0   <= wdata;
      end else begin
        csb0 <= 1'b1;
        web0 <= 1'b1;
      end
      p0        <= '{valid: hs && !we, client_id: id};
      p1        <= p0;
      rsp_valid <= {p1.valid && p1.client_id, p1.valid && !p1.client_id};
      rsp_rdata <= p1.valid ? dout0 : rsp_rdata;
    end
  end
endmodule

// File: tb/tb_sram_port0_arbiter.sv
// tb_sram_port0_arbiter: directed bench with a behavioural 1RW port-0 macro model
module tb_sram_port0_arbiter;
  logic clk0 = 1'b0, rstb0 = 1'b0;
  logic [1:0] req_valid = '0, req_we = '0, req_wmask = '0, req_ready, rsp_valid;
  logic [19:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [7:0] rsp_rdata, din0, dout0;
  logic csb0, web0, init_done;
  logic [0:0] wmask0;
  logic [9:0] addr0;
  int checks = 0, failures = 0;
  logic [7:0] mem [1024];
  logic m_csb = 1'b1, m_web = 1'b1;
  logic [0:0] m_wmask = '0;
  logic [9:0] m_addr = '0;
  logic [7:0] m_din = '0;

  sram_port0_arbiter dut (
    .clk0, .rstb0, .req_valid, .req_ready, .req_we, .req_addr, .req_wdata, .req_wmask,
    .rsp_valid, .rsp_rdata, .csb0, .web0, .wmask0, .addr0, .din0, .dout0, .init_done
  );

  always #5 clk0 = ~clk0;

  // macro latches pins at posedge, writes/reads at the following negedge
  always @(posedge clk0) begin
    m_csb   <= csb0;
    m_web   <= web0;
    m_wmask <= wmask0;
    m_addr  <= addr0;
    m_din   <= din0;
  end
  always @(negedge clk0) begin
    if (!m_csb && !m_web && m_wmask[0]) mem[m_addr] <= m_din;
    if (!m_csb && m_web) dout0 <= mem[m_addr];
  end

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk0);
    #1;
  endtask

  task automatic req(input int c, input logic we, input logic [9:0] a, input logic [7:0] d, input logic m);
    req_valid[c] = 1'b1;
    req_we[c] = we;
    req_addr[c*10 +: 10] = a;
    req_wdata[c*8 +: 8] = d;
    req_wmask[c] = m;
  endtask

  task automatic write(input int c, input logic [9:0] a, input logic [7:0] d, input logic m);
    req(c, 1'b1, a, d, m);
    #1;
    chk("wr_ready", req_ready, 1 << c);
    tick;
    req_valid = '0;
    chk("wr_csb", csb0, 0);
    chk("wr_web", web0, 0);
    chk("wr_addr", addr0, a);
    chk("wr_din", din0, d);
    chk("wr_mask", wmask0, m);
  endtask

  task automatic read_chk(input int c, input logic [9:0] a, input logic [7:0] exp);
    req(c, 1'b0, a, 8'h00, 1'b0);
    #1;
    chk("rd_ready", req_ready, 1 << c);
    tick;
    req_valid = '0;
    chk("rd_csb", csb0, 0);
    chk("rd_web", web0, 1);
    chk("rd_addr", addr0, a);
    tick;
    chk("rd_early", rsp_valid, 0);
    tick;
    chk("rd_valid", rsp_valid, 1 << c);
    chk("rd_data", rsp_rdata, exp);
    tick;
    chk("rd_pulse", rsp_valid, 0);
    chk("rd_hold", rsp_rdata, exp);
  endtask

  initial begin
    req(0, 1'b0, 10'h000, 8'h00, 1'b0);
    repeat (3) tick;
    #1;
    chk("rst_csb", csb0, 1);
    chk("rst_web", web0, 1);
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_addr", addr0, 0);
    chk("rst_rdata", rsp_rdata, 0);
`ifdef SRAM_PORT0_INIT_EN
    chk("rst_init_done", init_done, 0);
    rstb0 = 1'b1;
    for (int i = 0; i < 1023; i++) begin
      tick;
      chk("init_ready", req_ready, 0);
    end
    for (int k = 0; k < 8 && !init_done; k++) tick;
    chk("init_done", init_done, 1);
    req_valid = '0;
    read_chk(0, 10'h000, 8'h00);
    read_chk(0, 10'h3FF, 8'h00);
`else
    chk("rst_init_done", init_done, 1);
    req_valid = '0;
    rstb0 = 1'b1;
    tick;
    chk("init_done", init_done, 1);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("idle_pins", {csb0, web0, addr0}, {2'b11, 10'h000});
    end
`endif
    write(0, 10'h3FF, 8'hA5, 1'b1);
    read_chk(0, 10'h3FF, 8'hA5);
    write(0, 10'h001, 8'h11, 1'b1);
    write(1, 10'h002, 8'h22, 1'b1);
    write(1, 10'h3FF, 8'h5A, 1'b0);
    read_chk(1, 10'h3FF, 8'hA5);
    req(0, 1'b0, 10'h001, 8'h00, 1'b0);
    req(1, 1'b0, 10'h002, 8'h00, 1'b0);
    #1;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) chk("rr_ready", req_ready, (k % 2) ? 2'b10 : 2'b01);
      tick;
      if (k == 3) req_valid = '0;
      if (k >= 2) begin
        chk("rr_rsp", rsp_valid, (k % 2) ? 2'b10 : 2'b01);
        chk("rr_data", rsp_rdata, (k % 2) ? 8'h22 : 8'h11);
      end
    end
    tick;
    chk("rr_quiet", rsp_valid, 0);
    req(0, 1'b0, 10'h001, 8'h00, 1'b0);
    #1;
    chk("mr_ready", req_ready, 2'b01);
    tick;
    req_valid = '0;
    tick;
    rstb0 = 1'b0;
    tick;
    chk("mr_rsp", rsp_valid, 0);
    chk("mr_csb", csb0, 1);
    chk("mr_web", web0, 1);
    chk("mr_addr", addr0, 0);
    chk("mr_din", din0, 0);
    chk("mr_mask", wmask0, 0);
    chk("mr_rdata", rsp_rdata, 0);
    req(1, 1'b0, 10'h002, 8'h00, 1'b0);
    #1;
    chk("mr_ready", req_ready, 0);
    req_valid = '0;
    rstb0 = 1'b1;
    tick;
    chk("mr_after1", rsp_valid, 0);
    tick;
    chk("mr_after2", rsp_valid, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
